cpu_alu_seq: RTL and testbench

CPU_ALU_SEQ -- requirements
Module: cpu_alu_seq

---
 rtl/cpu_alu_seq_pkg.sv | 16 +
 rtl/cpu_alu_seq.sv | 106 ++++++++++
 tb/tb_cpu_alu_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_alu_seq_pkg.sv
// cpu_alu_seq_pkg: opcode encodings and status-flag bit positions shared by the CPU datapath.
package cpu_alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_INC  = 2'b11
    } op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cpu_alu_seq.sv
// cpu_alu_seq: bus-fed 8-bit ALU sequencer; loads one or two operands, runs PASS/ADD/SUB/INC
// through a single 9-bit adder and holds the result and N/Z/C/V flags until the next operation.
module cpu_alu_seq
    import cpu_alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       carry_in,
    input  logic       abort,
    input  logic [7:0] bus_in,
    input  logic       bus_valid,
    output logic       ready,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       flag_n,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_v
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_DONE
    } state_e;

    state_e      r_state;
    state_e      w_next;
    op_e         r_op;
    logic        r_cin;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [7:0]  r_result;
    logic [3:0]  r_flags;
    logic        w_two;
    logic [7:0]  w_b;
    logic        w_c0;
    logic [8:0]  w_sum;
    logic [7:0]  w_r;
    logic [3:0]  w_flags;

    assign w_two = (r_op == OP_ADD) || (r_op == OP_SUB);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = (start && !abort) ? S_LOAD_A : S_IDLE;
            S_LOAD_A: w_next = abort ? S_IDLE : !bus_valid ? S_LOAD_A : w_two ? S_LOAD_B : S_EXEC;
            S_LOAD_B: w_next = abort ? S_IDLE : bus_valid ? S_EXEC : S_LOAD_B;
            S_EXEC:   w_next = abort ? S_IDLE : S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    // SUB reuses the adder as A + ~B + C; INC feeds a constant 1 with no carry-in
    always_comb begin
        w_b   = (r_op == OP_SUB) ? ~r_b : (r_op == OP_INC) ? 8'h01 : r_b;
        w_c0  = w_two & r_cin;
        w_sum = {1'b0, r_a} + {1'b0, w_b} + {8'b0, w_c0};
        w_r   = (r_op == OP_PASS) ? r_a : w_sum[7:0];
        w_flags         = r_flags;
        w_flags[FLAG_N] = w_r[7];
        w_flags[FLAG_Z] = (w_r == 8'h00);
        w_flags[FLAG_C] = w_two ? w_sum[8] : r_flags[FLAG_C];
        w_flags[FLAG_V] = w_two ? ((r_a[7] == w_b[7]) && (w_r[7] != r_a[7])) : r_flags[FLAG_V];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_PASS;
            r_cin    <= 1'b0;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_result <= 8'h00;
            r_flags  <= 4'h0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start && !abort) begin
                r_op  <= op_e'(op);
                r_cin <= carry_in;
            end
            if (r_state == S_LOAD_A && bus_valid && !abort)
                r_a <= bus_in;
            if (r_state == S_LOAD_B && bus_valid && !abort)
                r_b <= bus_in;
            if (r_state == S_EXEC && !abort) begin
                r_result <= w_r;
                r_flags  <= w_flags;
            end
        end
    end

    assign ready        = (r_state == S_IDLE);
    assign result_valid = (r_state == S_DONE);
    assign result       = r_result;
    assign flag_n       = r_flags[FLAG_N];
    assign flag_z       = r_flags[FLAG_Z];
    assign flag_c       = r_flags[FLAG_C];
    assign flag_v       = r_flags[FLAG_V];

endmodule

// File: tb/tb_cpu_alu_seq.sv
// tb_cpu_alu_seq: random and directed operations against an arithmetic reference model;
// expected results are queued at issue and popped by an independent monitor on each result pulse.
module tb_cpu_alu_seq;

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic       carry_in;
    logic       abort;
    logic [7:0] bus_in;
    logic       bus_valid;
    logic       ready;
    logic [7:0] result;
    logic       result_valid;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    logic [7:0] m_res = 8'h00;
    logic       m_n = 1'b0;
    logic       m_z = 1'b0;
    logic       m_c = 1'b0;
    logic       m_v = 1'b0;

    cpu_alu_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op(op),
        .carry_in(carry_in),
        .abort(abort),
        .bus_in(bus_in),
        .bus_valid(bus_valid),
        .ready(ready),
        .result(result),
        .result_valid(result_valid),
        .flag_n(flag_n),
        .flag_z(flag_z),
        .flag_c(flag_c),
        .flag_v(flag_v)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Reference semantics: unsigned 9-bit carry and signed-range overflow, 6502-style borrow for SUB
    function automatic exp_t model(logic [1:0] o, logic ci, logic [7:0] a, logic [7:0] b, int due);
        exp_t e;
        int   s;
        int   sv;
        logic [7:0] r;
        case (o)
            2'b01: begin
                s  = int'(a) + int'(b) + int'(ci);
                sv = int'($signed(a)) + int'($signed(b)) + int'(ci);
                r  = s[7:0];
                m_c = (s > 255);
                m_v = (sv > 127) || (sv < -128);
            end
            2'b10: begin
                s  = int'(a) + (255 - int'(b)) + int'(ci);
                sv = int'($signed(a)) - int'($signed(b)) - (1 - int'(ci));
                r  = s[7:0];
                m_c = (s > 255);
                m_v = (sv > 127) || (sv < -128);
            end
            2'b11: begin
                s = (int'(a) + 1) % 256;
                r = s[7:0];
            end
            default: r = a;
        endcase
        m_res = r;
        m_n   = r[7];
        m_z   = (r == 8'h00);
        e.r   = r;
        e.f   = {m_n, m_z, m_c, m_v};
        e.due = due;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", {24'h0, result}, {24'h0, e.r});
                chk("flags_nzcv", {28'h0, flag_n, flag_z, flag_c, flag_v}, {28'h0, e.f});
                chk("latency", cyc, e.due);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {31'h0, ready}, 1);
    endtask

    task automatic chk_held(string nm);
        chk({nm, "_ready"}, {31'h0, ready}, 1);
        chk({nm, "_result"}, {24'h0, result}, {24'h0, m_res});
        chk({nm, "_flags"}, {28'h0, flag_n, flag_z, flag_c, flag_v}, {28'h0, m_n, m_z, m_c, m_v});
    endtask

    task automatic gap_cycles(int g);
        repeat (g) begin
            bus_valid = 1'b0;
            bus_in    = 8'($urandom);
            start     = 1'($urandom);
            op        = 2'($urandom);
            carry_in  = 1'($urandom);
            @(negedge clk);
            chk("busy_ready", {31'h0, ready}, 0);
        end
        start = 1'b0;
    endtask

    // ab: 0 none, 1 abort in LOAD_A, 2 abort in LOAD_B, 3 abort in EXEC, 4 reset in EXEC
    task automatic run(logic [1:0] o, logic ci, logic [7:0] a, logic [7:0] b, int ga, int gb, int ab);
        int  k;
        bit  two;
        two = (o == 2'b01) || (o == 2'b10);
        @(negedge clk);
        wait_ready();
        start     = 1'b1;
        op        = o;
        carry_in  = ci;
        abort     = 1'b0;
        bus_valid = 1'($urandom);
        bus_in    = 8'($urandom);
        @(negedge clk);
        k = cyc;
        start = 1'b0;
        gap_cycles(ga);
        bus_valid = 1'b1;
        bus_in    = a;
        if (ab == 1) begin
            abort = 1'b1;
            @(negedge clk);
            abort     = 1'b0;
            bus_valid = 1'b0;
            chk_held("abort_a");
            return;
        end
        @(negedge clk);
        if (two) begin
            gap_cycles(gb);
            bus_valid = 1'b1;
            bus_in    = b;
            if (ab == 2) begin
                abort = 1'b1;
                @(negedge clk);
                abort     = 1'b0;
                bus_valid = 1'b0;
                chk_held("abort_b");
                return;
            end
            @(negedge clk);
        end
        bus_valid = 1'($urandom);
        bus_in    = 8'($urandom);
        if (ab == 3) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk_held("abort_exec");
            return;
        end
        if (ab == 4) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_ready", {31'h0, ready}, 1);
            chk("rst_result", {24'h0, result}, 0);
            chk("rst_valid", {31'h0, result_valid}, 0);
            chk("rst_flags", {28'h0, flag_n, flag_z, flag_c, flag_v}, 0);
            {m_res, m_n, m_z, m_c, m_v} = '0;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (5) @(negedge clk);
            return;
        end
        sb.push_back(model(o, ci, a, b, k + ga + (two ? gb + 3 : 2)));
        @(negedge clk);
        abort = 1'($urandom);
        @(negedge clk);
        abort     = 1'b0;
        bus_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        carry_in  = 1'b0;
        abort     = 1'b0;
        bus_in    = 8'h00;
        bus_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'h0, ready}, 1);
        chk("reset_result", {24'h0, result}, 0);
        chk("reset_valid", {31'h0, result_valid}, 0);
        chk("reset_flags", {28'h0, flag_n, flag_z, flag_c, flag_v}, 0);
        rst_n = 1'b1;

        run(2'b01, 1'b0, 8'h50, 8'h50, 0, 0, 0);
        run(2'b10, 1'b1, 8'h00, 8'h01, 0, 0, 0);
        run(2'b01, 1'b0, 8'h80, 8'h80, 0, 0, 0);
        run(2'b11, 1'b0, 8'hFF, 8'h00, 0, 0, 0);
        run(2'b01, 1'b1, 8'h12, 8'h34, 0, 0, 2);
        run(2'b01, 1'b1, 8'h12, 8'h34, 0, 0, 0);
        run(2'b01, 1'b0, 8'h7F, 8'h01, 5, 0, 0);
        run(2'b10, 1'b0, 8'h33, 8'h22, 1, 1, 1);
        run(2'b00, 1'b0, 8'h00, 8'h00, 0, 0, 3);
        run(2'b00, 1'b0, 8'hC3, 8'h00, 2, 0, 0);

        @(negedge clk);
        wait_ready();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_blocks", {31'h0, ready}, 1);

        run(2'b01, 1'b1, 8'hAA, 8'h55, 0, 0, 4);
        run(2'b01, 1'b1, 8'hFF, 8'h00, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            int ab;
            ab = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 3)) : 0;
            run(2'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), ab);
        end

        repeat (6) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
